// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register: PC, fetch capture, bubble/stall/redirect,
// and immediate field slicing of the registered instruction for the ID stage.
module if_id_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_wait,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [4:0]  id_rs1,
    output logic [4:0]  id_rs2,
    output logic [4:0]  id_rd,
    output logic [4:0]  id_iimm_shamt,
    output logic [11:0] id_iimm,
    output logic [11:0] id_simm,
    output logic [11:0] id_bimm,
    output logic [19:0] id_uimm,
    output logic [19:0] id_jimm,
    output logic [2:0]  id_extop,
    output logic [31:0] fetch_cnt
);

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] EXT_I     = 3'b010;
    localparam logic [2:0] EXT_S     = 3'b001;
    localparam logic [2:0] EXT_B     = 3'b100;
    localparam logic [2:0] EXT_NONE  = 3'b000;

    // Word alignment is enforced on every PC source so pc[1:0] stays 00.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    logic [31:0] r_pc;
    logic        r_id_valid;
    logic [31:0] r_id_pc;
    logic [31:0] r_id_instr;
    logic [31:0] r_fetch_cnt;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_redirect_pc_aligned;
    logic [6:0]  w_opcode;

    assign w_pc_plus4            = r_pc + 32'd4;
    assign w_redirect_pc_aligned = {redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= RESET_PC_ALIGNED;
            r_id_valid  <= 1'b0;
            r_id_pc     <= 32'd0;
            r_id_instr  <= NOP_INSTR;
            r_fetch_cnt <= 32'd0;
        end else if (redirect) begin
            // Squash the wrong-path fetch; redirect outranks stall and imem_wait.
            r_pc       <= w_redirect_pc_aligned;
            r_id_valid <= 1'b0;
            r_id_pc    <= 32'd0;
            r_id_instr <= NOP_INSTR;
        end else if (stall) begin
            r_pc       <= r_pc;
            r_id_valid <= r_id_valid;
            r_id_pc    <= r_id_pc;
            r_id_instr <= r_id_instr;
        end else if (imem_wait) begin
            // ID keeps moving, so feed it a bubble while the fetch retries.
            r_pc       <= r_pc;
            r_id_valid <= 1'b0;
            r_id_pc    <= 32'd0;
            r_id_instr <= NOP_INSTR;
        end else begin
            r_pc        <= w_pc_plus4;
            r_id_valid  <= 1'b1;
            r_id_pc     <= r_pc;
            r_id_instr  <= imem_rdata;
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
        end
    end

    assign imem_addr = r_pc;
    assign id_valid  = r_id_valid;
    assign id_pc     = r_id_pc;
    assign id_instr  = r_id_instr;
    assign fetch_cnt = r_fetch_cnt;

    assign w_opcode      = r_id_instr[6:0];
    assign id_rs1        = r_id_instr[19:15];
    assign id_rs2        = r_id_instr[24:20];
    assign id_rd         = r_id_instr[11:7];
    assign id_iimm_shamt = r_id_instr[24:20];
    assign id_iimm       = r_id_instr[31:20];
    assign id_simm       = {r_id_instr[31:25], r_id_instr[11:7]};
    assign id_bimm       = {r_id_instr[31], r_id_instr[7], r_id_instr[30:25], r_id_instr[11:8]};
    assign id_uimm       = r_id_instr[31:12];
    assign id_jimm       = {r_id_instr[31], r_id_instr[19:12], r_id_instr[20], r_id_instr[30:21]};

    // U and J formats are handled elsewhere in ID, so they decode to EXT_NONE here.
    always_comb begin
        id_extop = EXT_NONE;
        case (w_opcode)
            OP_IMM, OP_LOAD, OP_JALR: id_extop = EXT_I;
            OP_STORE:                 id_extop = EXT_S;
            OP_BRANCH:                id_extop = EXT_B;
            default:                  id_extop = EXT_NONE;
        endcase
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed, table-driven bench for if_id_stage with hand-computed expectations.
module tb_if_id_stage;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_wait;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [4:0]  id_rs1, id_rs2, id_rd, id_iimm_shamt;
    logic [11:0] id_iimm, id_simm, id_bimm;
    logic [19:0] id_uimm, id_jimm;
    logic [2:0]  id_extop;
    logic [31:0] fetch_cnt;

    int checks   = 0;
    int failures = 0;

    if_id_stage dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .imem_wait     (imem_wait),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_instr      (id_instr),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_rd         (id_rd),
        .id_iimm_shamt (id_iimm_shamt),
        .id_iimm       (id_iimm),
        .id_simm       (id_simm),
        .id_bimm       (id_bimm),
        .id_uimm       (id_uimm),
        .id_jimm       (id_jimm),
        .id_extop      (id_extop),
        .fetch_cnt     (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        wait_;
        logic        redir;
        logic [31:0] rpc;
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_idpc;
        logic [31:0] exp_instr;
        logic [2:0]  exp_extop;
        logic [31:0] exp_cnt;
        logic        chk_imm;
        logic [11:0] exp_bimm;
        logic [11:0] exp_simm;
        logic [4:0]  exp_rs1;
        logic [4:0]  exp_rs2;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic w, input logic r, input logic [31:0] rpc,
                       input logic [31:0] rd, input logic [31:0] addr, input logic v,
                       input logic [31:0] idpc, input logic [31:0] ins, input logic [2:0] ext,
                       input logic [31:0] cnt);
        vec_t t;
        t.stall = s; t.wait_ = w; t.redir = r; t.rpc = rpc; t.rdata = rd;
        t.exp_addr = addr; t.exp_valid = v; t.exp_idpc = idpc; t.exp_instr = ins;
        t.exp_extop = ext; t.exp_cnt = cnt;
        t.chk_imm = 1'b0; t.exp_bimm = '0; t.exp_simm = '0; t.exp_rs1 = '0; t.exp_rs2 = '0;
        vecs.push_back(t);
    endtask

    task automatic add_imm(input logic [11:0] b, input logic [11:0] s,
                           input logic [4:0] r1, input logic [4:0] r2);
        vec_t t;
        t = vecs.pop_back();
        t.chk_imm = 1'b1; t.exp_bimm = b; t.exp_simm = s; t.exp_rs1 = r1; t.exp_rs2 = r2;
        vecs.push_back(t);
    endtask

    initial begin
        rst = 1'b1; imem_rdata = '0; imem_wait = 0; stall = 0; redirect = 0; redirect_pc = '0;

        //   stall wait redir rpc           rdata         addr          v  idpc          instr         ext     cnt
        add(0, 0, 0, 32'h0,          32'h00500093, 32'h4,        1, 32'h0,        32'h00500093, 3'b010, 1);
        add(0, 0, 0, 32'h0,          32'h00A00113, 32'h8,        1, 32'h4,        32'h00A00113, 3'b010, 2);
        add(0, 0, 0, 32'h0,          32'h002081B3, 32'hC,        1, 32'h8,        32'h002081B3, 3'b000, 3);
        add(1, 0, 0, 32'h0,          32'hDEADBEEF, 32'hC,        1, 32'h8,        32'h002081B3, 3'b000, 3);
        add(1, 0, 0, 32'h0,          32'hDEADBEEF, 32'hC,        1, 32'h8,        32'h002081B3, 3'b000, 3);
        add(0, 0, 0, 32'h0,          32'hFE209EE3, 32'h10,       1, 32'hC,        32'hFE209EE3, 3'b100, 4);
        add_imm(12'hFFE, 12'hFFD, 5'd1, 5'd2);
        add(0, 1, 0, 32'h0,          32'hDEADBEEF, 32'h10,       0, 32'h0,        32'h00000013, 3'b010, 4);
        add(0, 0, 0, 32'h0,          32'hFE112E23, 32'h14,       1, 32'h10,       32'hFE112E23, 3'b001, 5);
        add_imm(12'hBFE, 12'hFFC, 5'd2, 5'd1);
        add(1, 0, 1, 32'h00000102,   32'hDEADBEEF, 32'h100,      0, 32'h0,        32'h00000013, 3'b010, 5);
        add(0, 0, 0, 32'h0,          32'h00C00193, 32'h104,      1, 32'h100,      32'h00C00193, 3'b010, 6);
        add(0, 0, 0, 32'h0,          32'h123450B7, 32'h108,      1, 32'h104,      32'h123450B7, 3'b000, 7);
        add(0, 0, 0, 32'h0,          32'h0000A103, 32'h10C,      1, 32'h108,      32'h0000A103, 3'b010, 8);
        add(1, 1, 0, 32'h0,          32'hDEADBEEF, 32'h10C,      1, 32'h108,      32'h0000A103, 3'b010, 8);
        add(0, 1, 1, 32'hFFFFFFFF,   32'hDEADBEEF, 32'hFFFFFFFC, 0, 32'h0,        32'h00000013, 3'b010, 8);
        add(0, 0, 0, 32'h0,          32'h0000006F, 32'h0,        1, 32'hFFFFFFFC, 32'h0000006F, 3'b000, 9);
        add(0, 0, 0, 32'h0,          32'h00008067, 32'h4,        1, 32'h0,        32'h00008067, 3'b010, 10);

        // Reset state, asynchronous and before any clock edge.
        #1;
        chk("rst_addr",  imem_addr, 32'h0);
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_idpc",  id_pc, 32'h0);
        chk("rst_instr", id_instr, 32'h00000013);
        chk("rst_extop", {29'd0, id_extop}, 32'd2);
        chk("rst_cnt",   fetch_cnt, 32'd0);

        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            if (i != 0) @(negedge clk);
            stall = vecs[i].stall; imem_wait = vecs[i].wait_; redirect = vecs[i].redir;
            redirect_pc = vecs[i].rpc; imem_rdata = vecs[i].rdata;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_addr", i),  imem_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_valid", i), {31'd0, id_valid}, {31'd0, vecs[i].exp_valid});
            chk($sformatf("v%0d_idpc", i),  id_pc, vecs[i].exp_idpc);
            chk($sformatf("v%0d_instr", i), id_instr, vecs[i].exp_instr);
            chk($sformatf("v%0d_extop", i), {29'd0, id_extop}, {29'd0, vecs[i].exp_extop});
            chk($sformatf("v%0d_cnt", i),   fetch_cnt, vecs[i].exp_cnt);
            if (vecs[i].chk_imm) begin
                chk($sformatf("v%0d_bimm", i), {20'd0, id_bimm}, {20'd0, vecs[i].exp_bimm});
                chk($sformatf("v%0d_simm", i), {20'd0, id_simm}, {20'd0, vecs[i].exp_simm});
                chk($sformatf("v%0d_rs1", i),  {27'd0, id_rs1},  {27'd0, vecs[i].exp_rs1});
                chk($sformatf("v%0d_rs2", i),  {27'd0, id_rs2},  {27'd0, vecs[i].exp_rs2});
            end
        end

        // Field slices of the last captured word 0x00008067 (jalr x0,0(x1)).
        chk("jalr_rd",    {27'd0, id_rd},         32'd0);
        chk("jalr_iimm",  {20'd0, id_iimm},       32'd0);
        chk("jalr_shamt", {27'd0, id_iimm_shamt}, 32'd0);
        chk("jalr_uimm",  {12'd0, id_uimm},       32'h00008);

        // Mid-cycle reset must clear IF/ID without a clock edge.
        @(negedge clk);
        imem_rdata = 32'h800000B7;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'd0, id_valid}, 32'd0);
        chk("arst_addr",  imem_addr, 32'h0);
        chk("arst_instr", id_instr, 32'h00000013);
        chk("arst_cnt",   fetch_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rest_addr",  imem_addr, 32'h4);
        chk("rest_idpc",  id_pc, 32'h0);
        chk("rest_valid", {31'd0, id_valid}, 32'd1);
        chk("rest_uimm",  {12'd0, id_uimm}, 32'h80000);
        chk("rest_rd",    {27'd0, id_rd}, 32'd1);
        chk("rest_extop", {29'd0, id_extop}, 32'd0);

        // Branch penalty: redirect, one bubble, then target appears in ID.
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 32'h00000200; imem_rdata = 32'h12345678;
        @(negedge clk);
        redirect = 1'b0; imem_rdata = 32'hFFF00013;
        chk("bp_bubble", {31'd0, id_valid}, 32'd0);
        chk("bp_addr",   imem_addr, 32'h200);
        @(negedge clk);
        chk("bp_target_pc",   id_pc, 32'h200);
        chk("bp_target_iimm", {20'd0, id_iimm}, 32'hFFF);
        chk("bp_cnt",         fetch_cnt, 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Fetch stage plus IF/ID pipeline register for the RV32I lab CPU.
- Holds the PC and drives the instruction-memory address.
- Captures the fetched word into the IF/ID register with stall, bubble and redirect control.
- Slices the registered instruction into the immediate fields and 3-bit EXTOp consumed by the immediate extender in ID, so the ID stage needs no field decoding of its own.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction word held in the IF/ID register for a bubble (addi x0,x0,0).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_addr  output  32  fetch address = current PC.
- imem_rdata  input  32  instruction word for imem_addr, valid in the same cycle unless imem_wait=1.
- imem_wait  input  1  memory not ready this cycle; imem_rdata is invalid.
- stall  input  1  hazard-unit stall; hold PC and IF/ID.
- redirect  input  1  taken branch/jump resolved in EX.
- redirect_pc  input  32  target address for redirect.
- id_valid  output  1  IF/ID holds a real instruction.
- id_pc  output  32  PC of the IF/ID instruction.
- id_instr  output  32  IF/ID instruction word.
- id_rs1, id_rs2, id_rd  output  5 each  instr[19:15], [24:20], [11:7].
- id_iimm_shamt  output  5  instr[24:20].
- id_iimm  output  12  instr[31:20].
- id_simm  output  12  {instr[31:25], instr[11:7]}.
- id_bimm  output  12  {instr[31], instr[7], instr[30:25], instr[11:8]}.
- id_uimm  output  20  instr[31:12].
- id_jimm  output  20  {instr[31], instr[19:12], instr[20], instr[30:21]}.
- id_extop  output  3  3'b010 I-type, 3'b001 S-type, 3'b100 B-type, 3'b000 otherwise.
- fetch_cnt  output  32  count of instructions captured with valid=1.

Behaviour:
- Reset (async, immediate on rst=1):
  - pc=RESET_PC, id_valid=0, id_pc=0, id_instr=NOP_INSTR, fetch_cnt=0.
  - Field outputs follow NOP_INSTR, so id_extop=3'b010.
- imem_addr = pc, combinational. pc[1:0] is always 00.
- Per-edge update, first matching rule in priority order:
  1. redirect=1:
     - pc <= {redirect_pc[31:2], 2'b00}.
     - IF/ID <= bubble (valid 0, id_instr=NOP_INSTR, id_pc=0).
     - Overrides stall and imem_wait; the squashed slot does not count.
  2. stall=1:
     - pc and IF/ID unchanged (including id_valid), fetch_cnt unchanged.
  3. imem_wait=1:
     - pc unchanged; IF/ID <= bubble.
     - Downstream advances, so a bubble is inserted; no count.
  4. Otherwise:
     - pc <= pc + 4, wrapping modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
     - IF/ID <= {valid 1, id_pc=pc, id_instr=imem_rdata}.
     - fetch_cnt <= fetch_cnt + 1, wrapping at 2^32.
- Field outputs are combinational slices of the registered id_instr, valid in the same cycle as id_instr. There is no extra latency.
- id_extop is decoded from opcode id_instr[6:0]:
  - 0010011, 0000011, 1100111 -> 3'b010. This includes shift-immediates; shamt is carried on id_iimm_shamt.
  - 0100011 -> 3'b001.
  - 1100011 -> 3'b100.
  - Any other value, including LUI, AUIPC, JAL and illegal opcodes -> 3'b000.
- Fetch-to-ID latency: 1 cycle. Branch penalty: the redirect cycle inserts 1 bubble; the target appears in ID 2 edges after redirect is sampled.
- Reset asserted mid-stream discards IF/ID content immediately. Fetch restarts at RESET_PC on the first edge after rst deasserts.

Test Plan:
1. Reset, then 4 cycles of no stall with rdata = 0x00500093, 0x00A00113, 0x002081B3, 0xFE209EE3:
   - imem_addr goes 0, 4, 8, C.
   - id_pc lags by one cycle.
   - id_extop = 010, 010, 000, 100.
   - The last word gives id_bimm=12'hFFE.
   - fetch_cnt=4.
2. stall=1 for 2 cycles after capturing pc=8:
   - imem_addr stays 0xC.
   - id_pc stays 8 with id_valid=1.
   - fetch_cnt unchanged; the next free edge captures pc=0xC.
3. imem_wait=1 for 1 cycle at pc=0x10:
   - id_valid=0, id_instr=0x00000013 for one cycle.
   - pc holds at 0x10, then 0x10 is captured.
4. redirect=1 with redirect_pc=0x0000_0102, together with stall=1:
   - pc becomes 0x100.
   - id_valid=0 next cycle, then id_pc=0x100 with id_valid=1.
5. S-type word 0xFE112E23 (sw x1,-4(x2)):
   - id_extop=001, id_simm=12'hFFC, id_rs1=2, id_rs2=1.
6. pc forced to 0xFFFF_FFFC by redirect, then one free cycle:
   - pc wraps to 0x0000_0000.
   - Asserting rst mid-cycle drops id_valid to 0 without waiting for a clock edge.
